dcache: RTL and testbench

Data-side memory access unit between the load/store buffer and the byte-wide memory arbiter. Accepts one byte, half-word or word request per transaction from the load/store buffer. Serialises the request into little-endian byte accesses on the 8-bit memory port and returns either a zero-extended read word (`dataValid`) or a write-complete pulse (`dataWriteSuc`). It holds off I/O writes while the I/O buffer is full.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache.sv | 133 +++++++++++++
 tb/tb_dcache.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-side memory access unit.
package dcache_pkg;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_BYTE = 2'b01;
  localparam logic [1:0] ACC_HALF = 2'b10;
  localparam logic [1:0] ACC_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_RESP   = 2'b11
  } dcacheState_t;

  // I/O region predicate, shared with the load/store buffer; takes address bits [17:16].
  function automatic logic isIoAddr(input logic [1:0] addrHi);
    return addrHi == 2'b11;
  endfunction

  function automatic logic [2:0] accessBytes(input logic [1:0] acc);
    case (acc)
      ACC_BYTE: return 3'd1;
      ACC_HALF: return 3'd2;
      ACC_WORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dcache.sv
// Data-side memory access unit: serialises byte/half/word requests onto a byte-wide port.
module dcache #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataIn,
  output logic                  dataValid,
  output logic [31:0]           dataOut,
  output logic                  dataWriteSuc,
  output logic                  busy,
  output logic                  memReq,
  input  logic                  memGrant,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memDataOut,
  input  logic [7:0]            memDataIn,
  input  logic                  ioBufferFull
);
  import dcache_pkg::*;

  dcacheState_t          state;
  logic [2:0]            sizeN;
  logic                  isRead;
  logic                  isIo;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [31:0]           wrData;
  logic [2:0]            issued;
  logic                  pending;
  logic [1:0]            pendLane;
  logic [31:0]           asmData;

  logic                  fire;
  logic                  lastFire;
  logic [2:0]            issuedNext;
  logic                  stallNext;
  logic [31:0]           asmCapture;

  // Issue bookkeeping and the read byte arriving this cycle merged into the assembly word.
  always_comb begin
    fire       = (state == ST_ACCESS) && memReq && memGrant;
    issuedNext = issued + {2'b00, fire};
    lastFire   = fire && ((issued + 3'd1) == sizeN);
    stallNext  = isIo && !isRead && ioBufferFull;
    asmCapture = asmData;
    if (pending) begin
      asmCapture[{pendLane, 3'b000} +: 8] = memDataIn;
    end
  end

  // Transaction FSM with registered memory-port and response outputs.
  // The I/O stall is registered, so ioBufferFull in cycle c gates memReq in cycle c+1.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state        <= ST_IDLE;
      sizeN        <= '0;
      isRead       <= 1'b0;
      isIo         <= 1'b0;
      baseAddr     <= '0;
      wrData       <= '0;
      issued       <= '0;
      pending      <= 1'b0;
      pendLane     <= '0;
      asmData      <= '0;
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      dataOut      <= '0;
      busy         <= 1'b0;
      memReq       <= 1'b0;
      memWrite     <= 1'b0;
      memAddr      <= '0;
      memDataOut   <= '0;
    end else begin
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      pending      <= fire && isRead;
      pendLane     <= issued[1:0];
      asmData      <= asmCapture;
      case (state)
        ST_IDLE: begin
          if (accessType != ACC_NONE) begin
            state      <= ST_ACCESS;
            sizeN      <= accessBytes(accessType);
            isRead     <= readWriteIn;
            isIo       <= isIoAddr(dataAddr[17:16]);
            baseAddr   <= dataAddr;
            wrData     <= dataIn;
            issued     <= '0;
            asmData    <= '0;
            busy       <= 1'b1;
            memReq     <= !(isIoAddr(dataAddr[17:16]) && !readWriteIn && ioBufferFull);
            memWrite   <= !readWriteIn;
            memAddr    <= dataAddr;
            memDataOut <= dataIn[7:0];
          end
        end
        ST_ACCESS: begin
          issued     <= issuedNext;
          memAddr    <= baseAddr + ADDR_WIDTH'(issuedNext);
          memDataOut <= wrData[{issuedNext[1:0], 3'b000} +: 8];
          if (lastFire) begin
            memReq   <= 1'b0;
            memWrite <= 1'b0;
            if (isRead) begin
              state <= ST_DRAIN;
            end else begin
              state        <= ST_RESP;
              dataWriteSuc <= 1'b1;
            end
          end else begin
            memReq <= !stallNext;
          end
        end
        ST_DRAIN: begin
          if (pending) begin
            state     <= ST_RESP;
            dataValid <= 1'b1;
            dataOut   <= asmCapture;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache with a transaction-level reference model.
module tb_dcache;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b1;
  logic [1:0]  accessType = 2'b00;
  logic        readWriteIn = 1'b0;
  logic [31:0] dataAddr = '0;
  logic [31:0] dataIn = '0;
  logic        dataValid;
  logic [31:0] dataOut;
  logic        dataWriteSuc;
  logic        busy;
  logic        memReq;
  logic        memGrant = 1'b0;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [7:0]  memDataOut;
  logic [7:0]  memDataIn = '0;
  logic        ioBufferFull = 1'b0;

  int nChecks = 0;
  int nFail = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] lastRead = '0;

  dcache #(.ADDR_WIDTH(32)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .accessType(accessType),
    .readWriteIn(readWriteIn), .dataAddr(dataAddr), .dataIn(dataIn),
    .dataValid(dataValid), .dataOut(dataOut), .dataWriteSuc(dataWriteSuc),
    .busy(busy), .memReq(memReq), .memGrant(memGrant), .memWrite(memWrite),
    .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
    .ioBufferFull(ioBufferFull)
  );

  always #5 clockIn = ~clockIn;

  function automatic logic [7:0] memByte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Runs one transaction starting in the next cycle (cycle 0 = request cycle).
  // gMask/fMask give memGrant/ioBufferFull for cycles 0..15; afterwards grant=1, full=0.
  task automatic doTxn(input logic [1:0] acc, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [15:0] gMask,
                       input logic [15:0] fMask, input int extraAt,
                       output int respAt, output logic [31:0] rdata);
    int n;
    int k;
    bit stall;
    bit prevFull;
    bit g;
    bit f;
    bit expReq;
    bit issuedRead;
    bit done;
    logic [31:0] issuedAddr;
    logic [31:0] a;
    logic [31:0] expData;
    n = (acc == 2'b01) ? 1 : (acc == 2'b10) ? 2 : 4;
    stall = (addr[17:16] == 2'b11) && !rd;
    @(posedge clockIn); #1;
    nChecks++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("FAIL idleBusy: got %b expected 0", busy);
    end
    accessType = acc; readWriteIn = rd; dataAddr = addr; dataIn = wdata;
    memGrant = gMask[0]; ioBufferFull = fMask[0]; memDataIn = 8'($urandom);
    prevFull = fMask[0];
    k = 0; respAt = -1; issuedRead = 0; issuedAddr = '0; expData = '0; done = 0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(posedge clockIn); #1;
      if (c == extraAt) begin
        accessType = 2'b11; readWriteIn = 1'b1; dataAddr = 32'h500;
      end else begin
        accessType = 2'b00;
      end
      expReq = (k < n) && !(stall && prevFull);
      nChecks++;
      if (memReq !== expReq) begin
        nFail++;
        $display("FAIL memReq c%0d addr=%h: got %b expected %b", c, addr, memReq, expReq);
      end
      nChecks++;
      if (busy !== 1'b1) begin
        nFail++;
        $display("FAIL busy c%0d: got %b expected 1", c, busy);
      end
      nChecks++;
      if (dataValid !== (rd && c == respAt)) begin
        nFail++;
        $display("FAIL dataValid c%0d: got %b expected %b", c, dataValid, rd && c == respAt);
      end
      nChecks++;
      if (dataWriteSuc !== (!rd && c == respAt)) begin
        nFail++;
        $display("FAIL dataWriteSuc c%0d: got %b expected %b", c, dataWriteSuc, !rd && c == respAt);
      end
      if (expReq) begin
        nChecks++;
        if (memAddr !== addr + 32'(k) || memWrite !== !rd) begin
          nFail++;
          $display("FAIL memAddr c%0d: got %h/w%b expected %h/w%b", c, memAddr, memWrite, addr + 32'(k), !rd);
        end
        if (!rd) begin
          nChecks++;
          if (memDataOut !== wdata[8*k +: 8]) begin
            nFail++;
            $display("FAIL memDataOut c%0d: got %h expected %h", c, memDataOut, wdata[8*k +: 8]);
          end
        end
      end
      if (c == respAt) begin
        nChecks++;
        if (dataOut !== (rd ? expData : lastRead)) begin
          nFail++;
          $display("FAIL dataOut: got %h expected %h", dataOut, rd ? expData : lastRead);
        end
        if (rd) lastRead = expData;
        done = 1;
      end else begin
        g = (c < 16) ? gMask[c] : 1'b1;
        f = (c < 16) ? fMask[c] : 1'b0;
        memGrant = g; ioBufferFull = f;
        memDataIn = issuedRead ? memByte(issuedAddr) : 8'($urandom);
        issuedRead = 0;
        if (expReq && g) begin
          a = addr + 32'(k);
          if (rd) begin
            issuedRead = 1;
            issuedAddr = a;
            expData[8*k +: 8] = memByte(a);
          end else begin
            mem[a] = wdata[8*k +: 8];
          end
          k++;
          if (k == n) respAt = rd ? c + 2 : c + 1;
        end
        prevFull = f;
      end
    end
    if (!done) begin
      nChecks++;
      nFail++;
      $display("FAIL timeout: got no response expected one at cycle %0d", respAt);
    end
    rdata = expData;
    memGrant = 1'b0; ioBufferFull = 1'b0;
  endtask

  task automatic test_reset();
    resetIn = 1'b1;
    repeat (3) @(posedge clockIn);
    #1;
    nChecks++;
    if ({dataValid, dataWriteSuc, busy, memReq, memWrite} !== 5'b0 ||
        memAddr !== '0 || memDataOut !== '0 || dataOut !== '0) begin
      nFail++;
      $display("FAIL reset: got v%b s%b b%b r%b w%b a%h d%h o%h expected all zero",
               dataValid, dataWriteSuc, busy, memReq, memWrite, memAddr, memDataOut, dataOut);
    end
    resetIn = 1'b0;
    lastRead = '0;
  endtask

  task automatic test_word_read();
    int r;
    logic [31:0] d;
    mem[32'h100] = 8'h44; mem[32'h101] = 8'h33; mem[32'h102] = 8'h22; mem[32'h103] = 8'h11;
    doTxn(2'b11, 1'b1, 32'h100, '0, 16'hFFFF, 16'h0000, 0, r, d);
    nChecks++;
    if (r !== 6 || d !== 32'h11223344) begin
      nFail++;
      $display("FAIL wordRead: got cycle %0d data %h expected cycle 6 data 11223344", r, d);
    end
  endtask

  task automatic test_io_stall();
    int r;
    logic [31:0] d;
    doTxn(2'b01, 1'b0, 32'h30004, 32'h000000AB, 16'hFFFF, 16'h0007, 0, r, d);
    nChecks++;
    if (r !== 5 || memByte(32'h30004) !== 8'hAB) begin
      nFail++;
      $display("FAIL ioStall: got cycle %0d byte %h expected cycle 5 byte ab", r, memByte(32'h30004));
    end
    doTxn(2'b01, 1'b1, 32'h30010, '0, 16'hFFFF, 16'hFFFF, 0, r, d);
    nChecks++;
    if (r !== 3) begin
      nFail++;
      $display("FAIL ioReadNoStall: got cycle %0d expected 3", r);
    end
  endtask

  task automatic test_grant_drop();
    int r;
    logic [31:0] d;
    mem[32'h200] = 8'hFF; mem[32'h201] = 8'h80;
    doTxn(2'b10, 1'b1, 32'h200, '0, 16'hFFFB, 16'h0000, 0, r, d);
    nChecks++;
    if (r !== 5 || d !== 32'h000080FF) begin
      nFail++;
      $display("FAIL grantDrop: got cycle %0d data %h expected cycle 5 data 000080ff", r, d);
    end
  endtask

  task automatic test_wrap();
    int r;
    logic [31:0] d;
    doTxn(2'b10, 1'b0, 32'hFFFFFFFF, 32'h1234BEEF, 16'hFFFF, 16'h0000, 0, r, d);
    nChecks++;
    if (memByte(32'hFFFFFFFF) !== 8'hEF || memByte(32'h0) !== 8'hBE) begin
      nFail++;
      $display("FAIL wrapWrite: got %h %h expected ef be", memByte(32'hFFFFFFFF), memByte(32'h0));
    end
    doTxn(2'b10, 1'b1, 32'hFFFFFFFF, '0, 16'hFFFF, 16'h0000, 0, r, d);
    nChecks++;
    if (d !== 32'h0000BEEF) begin
      nFail++;
      $display("FAIL wrapRead: got %h expected 0000beef", d);
    end
  endtask

  task automatic test_reset_mid();
    int r;
    logic [31:0] d;
    @(posedge clockIn); #1;
    memGrant = 1'b1;
    accessType = 2'b11; readWriteIn = 1'b1; dataAddr = 32'h100;
    @(posedge clockIn); #1;
    accessType = 2'b00;
    memDataIn = 8'h44;
    @(posedge clockIn); #1;
    resetIn = 1'b1;
    @(posedge clockIn); #1;
    resetIn = 1'b0;
    nChecks++;
    if (busy !== 1'b0 || memReq !== 1'b0 || dataValid !== 1'b0) begin
      nFail++;
      $display("FAIL resetMid: got busy %b memReq %b dataValid %b expected 0 0 0", busy, memReq, dataValid);
    end
    lastRead = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clockIn); #1;
      nChecks++;
      if (dataValid !== 1'b0 || busy !== 1'b0 || memReq !== 1'b0) begin
        nFail++;
        $display("FAIL resetMidQuiet %0d: got v%b b%b r%b expected 0 0 0", i, dataValid, busy, memReq);
      end
    end
    memGrant = 1'b0;
    mem[32'h101] = 8'h5C;
    doTxn(2'b01, 1'b1, 32'h101, '0, 16'hFFFF, 16'h0000, 0, r, d);
    nChecks++;
    if (d !== 32'h0000005C || r !== 3) begin
      nFail++;
      $display("FAIL afterReset: got %h at cycle %0d expected 0000005c at cycle 3", d, r);
    end
  endtask

  task automatic test_busy_request();
    int r;
    logic [31:0] d;
    doTxn(2'b11, 1'b1, 32'h400, '0, 16'hFFFF, 16'h0000, 2, r, d);
    for (int i = 0; i < 4; i++) begin
      @(posedge clockIn); #1;
      nChecks++;
      if (dataValid !== 1'b0 || dataWriteSuc !== 1'b0 || busy !== 1'b0) begin
        nFail++;
        $display("FAIL busyRequest %0d: got v%b s%b b%b expected 0 0 0", i, dataValid, dataWriteSuc, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r;
    logic [31:0] d;
    logic [31:0] a;
    logic [1:0] acc;
    for (int i = 0; i < 40; i++) begin
      acc = 2'($urandom_range(1, 3));
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[17:16] = 2'b11;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      doTxn(acc, 1'($urandom), a, $urandom, 16'($urandom), 16'($urandom), 0, r, d);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_io_stall();
    test_grant_drop();
    test_wrap();
    test_reset_mid();
    test_busy_request();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
